// File: rtl/gate_test_sequencer.sv
// Drives a 2-input / 3-output gate unit through 00,01,10,11, samples its outputs
// after a settle time and accumulates a per-vector error map and count.
module gate_test_sequencer #(
    parameter int unsigned HOLD   = 2,
    parameter logic [3:0]  EXP_Y1 = 4'b1000,
    parameter logic [3:0]  EXP_Y2 = 4'b1110,
    parameter logic [3:0]  EXP_Y3 = 4'b0110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_map,
    output logic [2:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] err_map_nxt;
    logic [2:0] err_cnt_nxt;
    logic       pass_nxt;
    logic [2:0] exp_y;
    logic       mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            cnt     <= 4'd0;
            err_map <= 4'd0;
            err_cnt <= 3'd0;
            pass    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            err_map <= err_map_nxt;
            err_cnt <= err_cnt_nxt;
            pass    <= pass_nxt;
        end
    end

    assign exp_y    = {EXP_Y3[idx], EXP_Y2[idx], EXP_Y1[idx]};
    assign mismatch = (y != exp_y);

    // A new run may be launched from IDLE or DONE; start is ignored while busy.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        err_map_nxt = err_map;
        err_cnt_nxt = err_cnt;
        pass_nxt    = pass;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = SETTLE;
                    idx_nxt     = 2'd0;
                    cnt_nxt     = 4'd0;
                    err_map_nxt = 4'd0;
                    err_cnt_nxt = 3'd0;
                    pass_nxt    = 1'b0;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == HOLD_LAST) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                cnt_nxt = 4'd0;
                if (mismatch) begin
                    err_map_nxt[idx] = 1'b1;
                    err_cnt_nxt      = err_cnt + 3'd1;
                end
                if (idx == 2'd3) begin
                    state_nxt = DONE;
                    idx_nxt   = 2'd0;
                    pass_nxt  = (err_cnt_nxt == 3'd0);
                end else begin
                    state_nxt = SETTLE;
                    idx_nxt   = idx + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign a    = idx[1];
    assign b    = idx[0];
    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

endmodule
